// File: rtl/cisr_row_decoder.sv
// cisr_row_decoder: tags value/index beats with CISR-order row ids from per-lane row-length FIFOs.
// Optional `define CISR_DECODER_STATS_EN adds beat/row/stall counters.
module cisr_row_decoder #(
  parameter int NUM_CHANNELS = 4,
  parameter int VAL_W = 32,
  parameter int IDX_W = 32,
  parameter int LEN_W = 16,
  parameter int ROW_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_ROWS = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic rl_valid,
  output logic rl_ready,
  input  logic [NUM_CHANNELS*LEN_W-1:0] rl_data,
  input  logic rl_last,
  input  logic vi_valid,
  output logic vi_ready,
  input  logic [NUM_CHANNELS*VAL_W-1:0] vi_values,
  input  logic [NUM_CHANNELS*IDX_W-1:0] vi_col_idx,
  output logic out_valid,
  input  logic out_ready,
  output logic [NUM_CHANNELS*VAL_W-1:0] out_values,
  output logic [NUM_CHANNELS*IDX_W-1:0] out_col_id,
  output logic [NUM_CHANNELS*ROW_W-1:0] out_row_id,
  output logic [NUM_CHANNELS-1:0] out_lane_vld,
  output logic matrix_done,
  output logic err_extra,
  output logic err_row_ovf
`ifdef CISR_DECODER_STATS_EN
  ,
  output logic [31:0] stat_beats,
  output logic [31:0] stat_rows,
  output logic [31:0] stat_stall
`endif
);
  localparam int N = NUM_CHANNELS;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef logic [ROW_W:0] rid_t;
  localparam rid_t MAXR = rid_t'(MAX_ROWS);
  typedef enum logic [1:0] {LOAD, RUN, DONE} lane_t;
  lane_t st [N];
  lane_t st_nx [N];
  logic [LEN_W-1:0] mem [N][FIFO_DEPTH];
  logic [AW-1:0] wp [N];
  logic [AW-1:0] rp [N];
  logic [AW:0] cnt [N];
  logic [LEN_W-1:0] rem [N];
  logic [LEN_W-1:0] head [N];
  logic [ROW_W-1:0] row_id [N];
  rid_t alloc [N];
  rid_t alloc_end;
  logic [ROW_W-1:0] next_row_id;
  logic [N-1:0] pop, can_push, is_load, is_done, req_ovf;
  logic last_seen, push, accept, all_done, mdone;
  // ids are handed out in ascending lane order among lanes popping this cycle
  always_comb begin
    alloc_end = rid_t'(next_row_id);
    for (int c = 0; c < N; c++) begin
      head[c] = mem[c][rp[c]];
      is_load[c] = st[c] == LOAD;
      is_done[c] = st[c] == DONE;
      pop[c] = is_load[c] && cnt[c] != '0;
      can_push[c] = cnt[c] != (AW+1)'(FIFO_DEPTH) || pop[c];
      alloc[c] = alloc_end;
      req_ovf[c] = pop[c] && alloc_end >= MAXR;
      alloc_end = alloc_end + rid_t'(pop[c]);
    end
  end
  assign all_done = &is_done;
  assign push = rl_valid && rl_ready;
  assign rl_ready = &can_push;
  assign vi_ready = !(|is_load) && (!out_valid || out_ready) && !all_done;
  assign accept = vi_valid && vi_ready;
  assign mdone = all_done && !out_valid;
  assign matrix_done = mdone;
  always_comb
    for (int c = 0; c < N; c++)
      st_nx[c] = mdone ? LOAD :
                 st[c] == LOAD ? (pop[c] ? (head[c] != '0 ? RUN : LOAD) : (last_seen ? DONE : LOAD)) :
                 st[c] == RUN ? (accept && rem[c] == LEN_W'(1) ? LOAD : RUN) : DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int c = 0; c < N; c++) st[c] <= LOAD;
    else st <= st_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        wp[c] <= '0;
        rp[c] <= '0;
        cnt[c] <= '0;
        rem[c] <= '0;
        row_id[c] <= '0;
      end
      next_row_id <= '0;
      last_seen <= 1'b0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (push) wp[c] <= wp[c] + 1'b1;
        if (pop[c]) begin
          rp[c] <= rp[c] + 1'b1;
          rem[c] <= head[c];
          row_id[c] <= alloc[c] >= MAXR ? ROW_W'(MAX_ROWS - 1) : alloc[c][ROW_W-1:0];
        end else if (st[c] == RUN && accept && rem[c] != LEN_W'(1))
          rem[c] <= rem[c] - 1'b1;
        cnt[c] <= cnt[c] + (AW+1)'(push) - (AW+1)'(pop[c]);
      end
      next_row_id <= mdone ? '0 : alloc_end >= MAXR ? ROW_W'(MAX_ROWS) : alloc_end[ROW_W-1:0];
      last_seen <= !mdone && (last_seen || (push && rl_last));
    end
  always_ff @(posedge clk)
    if (push)
      for (int c = 0; c < N; c++) mem[c][wp[c]] <= rl_data[c*LEN_W +: LEN_W];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_values <= '0;
      out_col_id <= '0;
      out_row_id <= '0;
      out_lane_vld <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_values <= vi_values;
      out_col_id <= vi_col_idx;
      for (int c = 0; c < N; c++) begin
        out_lane_vld[c] <= !is_done[c];
        out_row_id[c*ROW_W +: ROW_W] <= is_done[c] ? '0 : row_id[c];
      end
    end else if (out_ready) out_valid <= 1'b0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      err_extra <= 1'b0;
      err_row_ovf <= 1'b0;
    end else begin
      err_extra <= err_extra || (vi_valid && all_done && !mdone);
      err_row_ovf <= err_row_ovf || (|req_ovf);
    end
`ifdef CISR_DECODER_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_beats <= '0;
      stat_rows <= '0;
      stat_stall <= '0;
    end else begin
      stat_beats <= stat_beats + 32'(accept);
      stat_rows <= stat_rows + 32'($countones(pop));
      stat_stall <= stat_stall + 32'(vi_valid && !vi_ready);
    end
`endif
endmodule
